// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between the requesters, the arbiter and the UART transmitter.
// The slave modport is the arbiter's view. The master modport is the system/requester view.
interface uart_tx_arbiter_if #(
   parameter int NumReq = 2
);
   logic [NumReq-1:0]   req_valid_i;
   logic [8*NumReq-1:0] req_data_i;
   logic [NumReq-1:0]   req_last_i;
   logic [NumReq-1:0]   req_ready_o;
   logic                tx_valid_o;
   logic [7:0]          tx_data_o;
   logic                tx_ready_i;
   logic [NumReq-1:0]   grant_o;
   logic                busy_o;

   modport slave (
      input  req_valid_i, req_data_i, req_last_i, tx_ready_i,
      output req_ready_o, tx_valid_o, tx_data_o, grant_o, busy_o
   );

   modport master (
      output req_valid_i, req_data_i, req_last_i, tx_ready_i,
      input  req_ready_o, tx_valid_o, tx_data_o, grant_o, busy_o
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NumReq byte streams. A requester holds the lock
// for a whole message. The lock is released on a last byte or after an idle timeout.
module uart_tx_arbiter #(
   parameter int NumReq      = 2,
   parameter int LockTimeout = 1024
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   uart_tx_arbiter_if.slave bus
);
   localparam int PtrW = $clog2(NumReq);
   localparam int CntW = $clog2(LockTimeout);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t          state_reg, state_next;
   logic [PtrW-1:0] rr_ptr_reg, rr_ptr_next;
   logic [PtrW-1:0] owner_reg, owner_next;
   logic [CntW-1:0] idle_cnt_reg, idle_cnt_next;
   logic            buf_valid_reg, buf_valid_next;
   logic [7:0]      buf_data_reg, buf_data_next;

   logic            locked;
   logic            slot_free;
   logic            owner_valid;
   logic            owner_last;
   logic [7:0]      owner_data;
   logic            owner_hs;
   logic            timeout_hit;
   logic [PtrW-1:0] sel;
   logic [PtrW-1:0] owner_inc;

   assign locked      = (state_reg == LOCKED);
   assign slot_free   = !buf_valid_reg || bus.tx_ready_i;
   assign owner_valid = bus.req_valid_i[owner_reg];
   assign owner_last  = bus.req_last_i[owner_reg];
   assign owner_data  = bus.req_data_i[{owner_reg, 3'b000} +: 8];
   assign owner_hs    = locked && owner_valid && slot_free;
   assign timeout_hit = locked && !owner_valid && (idle_cnt_reg == CntW'(LockTimeout - 1));
   assign owner_inc   = (owner_reg == PtrW'(NumReq - 1)) ? '0 : owner_reg + 1'b1;

   // Round-robin pick: scan downward so the candidate closest to rr_ptr wins.
   always_comb begin
      int idx;
      sel = rr_ptr_reg;
      idx = 0;
      for (int k = NumReq - 1; k >= 0; k--) begin
         idx = int'(rr_ptr_reg) + k;
         if (idx >= NumReq) idx = idx - NumReq;
         if (bus.req_valid_i[idx]) sel = PtrW'(idx);
      end
   end

   generate
      for (genvar gi = 0; gi < NumReq; gi++) begin : g_req
         assign bus.grant_o[gi]     = locked && (owner_reg == PtrW'(gi));
         assign bus.req_ready_o[gi] = locked && (owner_reg == PtrW'(gi)) && slot_free;
      end
   endgenerate

   assign bus.busy_o     = locked;
   assign bus.tx_valid_o = buf_valid_reg;
   assign bus.tx_data_o  = buf_data_reg;

   always_comb begin
      state_next     = state_reg;
      rr_ptr_next    = rr_ptr_reg;
      owner_next     = owner_reg;
      idle_cnt_next  = idle_cnt_reg;
      buf_valid_next = buf_valid_reg;
      buf_data_next  = buf_data_reg;

      // The buffer drains in either state so a release never strands a byte.
      if (owner_hs) begin
         buf_valid_next = 1'b1;
         buf_data_next  = owner_data;
      end else if (bus.tx_ready_i) begin
         buf_valid_next = 1'b0;
      end

      case (state_reg)
         IDLE: begin
            if (|bus.req_valid_i) begin
               state_next    = LOCKED;
               owner_next    = sel;
               idle_cnt_next = '0;
            end
         end
         LOCKED: begin
            idle_cnt_next = owner_valid ? '0 : idle_cnt_reg + 1'b1;
            if ((owner_hs && owner_last) || timeout_hit) begin
               state_next  = IDLE;
               rr_ptr_next = owner_inc;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg     <= IDLE;
         rr_ptr_reg    <= '0;
         owner_reg     <= '0;
         idle_cnt_reg  <= '0;
         buf_valid_reg <= 1'b0;
         buf_data_reg  <= 8'h00;
      end else begin
         state_reg     <= state_next;
         rr_ptr_reg    <= rr_ptr_next;
         owner_reg     <= owner_next;
         idle_cnt_reg  <= idle_cnt_next;
         buf_valid_reg <= buf_valid_next;
         buf_data_reg  <= buf_data_next;
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with two requesters and a 16-cycle lock timeout.
// Each vector row gives the inputs and the expected outputs for one clock cycle.
module tb_uart_tx_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NumReq(2)) bus ();

   uart_tx_arbiter #(.NumReq(2), .LockTimeout(16)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic       rst;
      logic [1:0] valid;
      logic [7:0] d0;
      logic [7:0] d1;
      logic [1:0] last;
      logic       txr;
      logic [1:0] e_ready;
      logic       e_txv;
      logic [7:0] e_txd;
      logic [1:0] e_grant;
      logic       e_busy;
   } vec_t;

   int   n_cmp = 0;
   int   n_err = 0;
   vec_t vecs[24];

   function automatic vec_t mk(logic rst, logic [1:0] valid, logic [7:0] d0, logic [7:0] d1,
                               logic [1:0] last, logic txr, logic [1:0] e_ready, logic e_txv,
                               logic [7:0] e_txd, logic [1:0] e_grant, logic e_busy);
      vec_t v;
      v.rst = rst; v.valid = valid; v.d0 = d0; v.d1 = d1; v.last = last; v.txr = txr;
      v.e_ready = e_ready; v.e_txv = e_txv; v.e_txd = e_txd; v.e_grant = e_grant; v.e_busy = e_busy;
      return v;
   endfunction

   task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [1:0] l, input logic t);
      bus.req_valid_i = v;
      bus.req_data_i  = {d1, d0};
      bus.req_last_i  = l;
      bus.tx_ready_i  = t;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [1:0] r, input logic txv,
                            input logic [7:0] txd, input logic [1:0] g, input logic b);
      check({tag, ".req_ready"}, 32'(bus.req_ready_o), 32'(r));
      check({tag, ".tx_valid"},  32'(bus.tx_valid_o),  32'(txv));
      check({tag, ".tx_data"},   32'(bus.tx_data_o),   32'(txd));
      check({tag, ".grant"},     32'(bus.grant_o),     32'(g));
      check({tag, ".busy"},      32'(bus.busy_o),      32'(b));
      $display("%s: ready=%b tx_valid=%b tx_data=%02h grant=%b busy=%b", tag,
               bus.req_ready_o, bus.tx_valid_o, bus.tx_data_o, bus.grant_o, bus.busy_o);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b1);

      //               rst valid d0     d1     last  txr  ready txv txd    grant busy
      // single requester 0: 0x48, 0x69(last)
      vecs[0]  = mk(1, 2'b00, 8'h00, 8'h00, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00, 0);
      vecs[1]  = mk(0, 2'b01, 8'h48, 8'h00, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00, 0);
      vecs[2]  = mk(0, 2'b01, 8'h48, 8'h00, 2'b00, 1, 2'b01, 0, 8'h00, 2'b01, 1);
      vecs[3]  = mk(0, 2'b01, 8'h69, 8'h00, 2'b01, 1, 2'b01, 1, 8'h48, 2'b01, 1);
      vecs[4]  = mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 1, 2'b00, 1, 8'h69, 2'b00, 0);
      vecs[5]  = mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 1, 2'b00, 0, 8'h69, 2'b00, 0);
      // contention from reset: round-robin 0 -> 1 -> 0
      vecs[6]  = mk(1, 2'b11, 8'hA0, 8'hB0, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00, 0);
      vecs[7]  = mk(0, 2'b11, 8'hA0, 8'hB0, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00, 0);
      vecs[8]  = mk(0, 2'b11, 8'hA1, 8'hB0, 2'b01, 1, 2'b01, 0, 8'h00, 2'b01, 1);
      vecs[9]  = mk(0, 2'b11, 8'hA2, 8'hB0, 2'b00, 1, 2'b00, 1, 8'hA1, 2'b00, 0);
      vecs[10] = mk(0, 2'b11, 8'hA2, 8'hB0, 2'b10, 1, 2'b10, 0, 8'hA1, 2'b10, 1);
      vecs[11] = mk(0, 2'b11, 8'hA2, 8'hB1, 2'b00, 1, 2'b00, 1, 8'hB0, 2'b00, 0);
      vecs[12] = mk(0, 2'b01, 8'hA2, 8'h00, 2'b01, 1, 2'b01, 0, 8'hB0, 2'b01, 1);
      vecs[13] = mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 1, 2'b00, 1, 8'hA2, 2'b00, 0);
      // requester 1 locked while requester 0 waits, with a short transmitter stall
      vecs[14] = mk(0, 2'b11, 8'hC0, 8'hD0, 2'b00, 1, 2'b00, 0, 8'hA2, 2'b00, 0);
      vecs[15] = mk(0, 2'b11, 8'hC0, 8'hD0, 2'b00, 1, 2'b10, 0, 8'hA2, 2'b10, 1);
      vecs[16] = mk(0, 2'b11, 8'hC0, 8'hD1, 2'b00, 0, 2'b00, 1, 8'hD0, 2'b10, 1);
      vecs[17] = mk(0, 2'b11, 8'hC0, 8'hD1, 2'b00, 0, 2'b00, 1, 8'hD0, 2'b10, 1);
      vecs[18] = mk(0, 2'b11, 8'hC0, 8'hD1, 2'b00, 1, 2'b10, 1, 8'hD0, 2'b10, 1);
      vecs[19] = mk(0, 2'b11, 8'hC0, 8'hD2, 2'b10, 1, 2'b10, 1, 8'hD1, 2'b10, 1);
      vecs[20] = mk(0, 2'b01, 8'hC0, 8'h00, 2'b00, 1, 2'b00, 1, 8'hD2, 2'b00, 0);
      vecs[21] = mk(0, 2'b01, 8'hC0, 8'h00, 2'b01, 1, 2'b01, 0, 8'hD2, 2'b01, 1);
      vecs[22] = mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 1, 2'b00, 1, 8'hC0, 2'b00, 0);
      vecs[23] = mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 1, 2'b00, 0, 8'hC0, 2'b00, 0);

      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         rst_n = !vecs[i].rst;
         drive(vecs[i].valid, vecs[i].d0, vecs[i].d1, vecs[i].last, vecs[i].txr);
         #1;
         check_all($sformatf("row%0d", i), vecs[i].e_ready, vecs[i].e_txv, vecs[i].e_txd,
                   vecs[i].e_grant, vecs[i].e_busy);
      end

      // Timeout: owner 0 stops after 0x55, release exactly 16 cycles later.
      do_reset();
      drive(2'b01, 8'h55, 8'h00, 2'b00, 1'b1);
      #1 check_all("to_idle", 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
      @(negedge clk);
      #1 check_all("to_lock", 2'b01, 1'b0, 8'h00, 2'b01, 1'b1);
      @(negedge clk);
      drive(2'b10, 8'h00, 8'h77, 2'b00, 1'b1);
      #1 check_all("to_n0", 2'b01, 1'b1, 8'h55, 2'b01, 1'b1);
      for (int k = 1; k < 16; k++) begin
         @(negedge clk);
         #1;
         check($sformatf("to_n%0d.busy", k), 32'(bus.busy_o), 32'd1);
         check($sformatf("to_n%0d.tx_valid", k), 32'(bus.tx_valid_o), 32'd0);
      end
      @(negedge clk);
      #1 check_all("to_release", 2'b00, 1'b0, 8'h55, 2'b00, 1'b0);
      @(negedge clk);
      #1 check_all("to_next_owner", 2'b10, 1'b0, 8'h55, 2'b10, 1'b1);

      // Transmitter stalled for 10 cycles while a byte is buffered.
      do_reset();
      drive(2'b01, 8'h10, 8'h00, 2'b00, 1'b1);
      #1 check_all("st_idle", 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
      @(negedge clk);
      #1 check_all("st_lock", 2'b01, 1'b0, 8'h00, 2'b01, 1'b1);
      @(negedge clk);
      drive(2'b01, 8'h11, 8'h00, 2'b00, 1'b0);
      for (int k = 0; k < 10; k++) begin
         #1 check_all($sformatf("st_stall%0d", k), 2'b00, 1'b1, 8'h10, 2'b01, 1'b1);
         @(negedge clk);
      end
      drive(2'b01, 8'h11, 8'h00, 2'b00, 1'b1);
      #1 check_all("st_resume", 2'b01, 1'b1, 8'h10, 2'b01, 1'b1);
      @(negedge clk);
      drive(2'b01, 8'h12, 8'h00, 2'b01, 1'b1);
      #1 check_all("st_b11", 2'b01, 1'b1, 8'h11, 2'b01, 1'b1);
      @(negedge clk);
      drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b1);
      #1 check_all("st_b12", 2'b00, 1'b1, 8'h12, 2'b00, 1'b0);
      @(negedge clk);
      #1 check_all("st_drained", 2'b00, 1'b0, 8'h12, 2'b00, 1'b0);

      // Asynchronous reset while 0xA5 is buffered.
      do_reset();
      drive(2'b01, 8'hA5, 8'h00, 2'b00, 1'b0);
      @(negedge clk);
      #1 check_all("rs_lock", 2'b01, 1'b0, 8'h00, 2'b01, 1'b1);
      @(negedge clk);
      drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b0);
      #1 check_all("rs_held", 2'b00, 1'b1, 8'hA5, 2'b01, 1'b1);
      #1 rst_n = 1'b0;
      #1 check_all("rs_async", 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b1);
      #1 check_all("rs_after", 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
      @(negedge clk);
      #1 check_all("rs_after2", 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single system UART transmitter between several byte-stream requesters (e.g. core UART peripheral, debug/trace source) with message-level locking. A requester is granted ownership, streams bytes until it marks end-of-message or goes silent past a timeout, then ownership passes round-robin. One registered output stage sits between the owner and the transmitter, whose byte input it drives with valid/ready.

## Interface
- NumReq, 2: number of requesters (2..8).
- LockTimeout, 1024: idle cycles (owner valid low) before forced release; ≥2.
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  NumReq  per-requester byte valid.
- req_data_i  in  8*NumReq  per-requester byte; requester i at bits [8i+7:8i].
- req_last_i  in  NumReq  byte is final byte of the message.
- req_ready_o  out  NumReq  byte accepted from requester i when valid&ready.
- tx_valid_o  out  1  byte valid to transmitter.
- tx_data_o  out  8  byte to transmitter.
- tx_ready_i  in  1  transmitter accepts byte.
- grant_o  out  NumReq  one-hot current owner; all zero when idle.
- busy_o  out  1  high while locked to an owner.

## Operation
- States: IDLE, LOCKED.
- IDLE: if any req_valid_i set, select first set bit searching from (rr_ptr) upward modulo NumReq; go LOCKED, owner := selection. No bytes accepted in IDLE.
- LOCKED: req_ready_o[owner] = !buf_valid | tx_ready_i; all other req_ready_o = 0.
- Output buffer (1 entry): on owner handshake, buf_data := req_data_i[owner], buf_valid := 1; else if tx_ready_i, buf_valid := 0. tx_valid_o = buf_valid, tx_data_o = buf_data (registered).
- Release on owner handshake with req_last_i[owner]=1: next state IDLE, rr_ptr := (owner+1) mod NumReq.
- Timeout: idle_cnt clears on entry to LOCKED and on any cycle req_valid_i[owner]=1; otherwise increments. When idle_cnt == LockTimeout-1 and owner valid low, release exactly as for last.
- Release never drops a byte: buffered byte is still presented until tx_ready_i.
- Non-owner valid never affects state, counter or buffer while LOCKED.
- Requester dropping valid without handshake is permitted (no protocol check).

## Timing
- Reset values: state IDLE, rr_ptr 0, owner 0, idle_cnt 0, buf_valid 0, buf_data 0x00; thus tx_valid_o 0, tx_data_o 0x00, grant_o 0, busy_o 0, req_ready_o all 0.
- Arbitration latency: valid seen in IDLE at cycle N -> grant_o/busy_o high and req_ready_o eligible at N+1.
- Byte latency: handshake at cycle N -> tx_valid_o with that byte at N+1.
- Throughput: one byte/cycle when tx_ready_i held high (buffer drained and refilled same cycle).
- Release: handshake with last at N -> IDLE at N+1, next owner granted at N+2 (one dead cycle).
- Timeout: owner valid low from cycle N onward (first idle cycle counts as 0) -> IDLE at N+LockTimeout.
- Simultaneous: last handshake and tx_ready_i in same cycle -> buffer refilled with last byte, state IDLE next.
- Reset mid-message: asynchronous; buffered byte discarded, outputs at reset values immediately.

## Test plan
- Single requester 0 sends 0x48,0x69(last) with tx_ready_i=1 -> grant_o=01 one cycle after valid, tx bytes 0x48,0x69 on consecutive cycles, busy_o falls after 0x69 handshake.
- Both requesters valid from reset -> req 0 granted first; after its last, req 1 granted at release+2; next contention grants req 0 again (round-robin).
- Requester 1 locked, requester 0 valid throughout -> req_ready_o[0] stays 0 and no req-0 byte appears until req 1 issues last.
- Owner stops after 0x55 without last, LockTimeout=16 -> release exactly 16 cycles after valid drops; 0x55 still delivered; other requester then granted.
- tx_ready_i low for 10 cycles mid-stream -> tx_valid_o/tx_data_o stable, req_ready_o[owner]=0, no byte lost or duplicated when ready returns.
- Assert rst_ni while buffer holds 0xA5 -> tx_valid_o, grant_o, busy_o drop without a clock edge; 0xA5 never transmitted.
